// File: rtl/bcd_counter.sv
// rtl/bcd_counter.sv - packed-BCD score counter with count enable and wrap carry
//
// Purpose: free-running DIGITS-digit decimal up-counter held as packed BCD.
//   Each enabled clock adds one. Digit 0 always steps; digit k steps when
//   every lower digit is at (or above) 9. q comes straight from the digit
//   registers so the display can read it digit by digit.
//
// Ports:
//   clk    in   1           rising-edge clock
//   clr    in   1           asynchronous active-high clear of q and carry
//   en     in   1           count enable, sampled on rising clk
//   q      out  4*DIGITS    packed BCD count, digit k in q[4k+3:4k]
//   carry  out  1           registered one-cycle pulse on wrap to zero
//
// Configuration: define BCD_COUNTER_SATURATE_EN to saturate at all-9s
//   instead of wrapping; carry then pulses once on arrival at all-9s.
module bcd_counter #(
  parameter int DIGITS = 8
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                en,
  output logic [4*DIGITS-1:0] q,
  output logic                carry
);

  logic [4*DIGITS-1:0] q_inc;
  logic                run;   // digit-step enable walking up the chain
  logic                wrap;  // every digit >= 9: increment rolls over
`ifdef BCD_COUNTER_SATURATE_EN
  logic                next_all_nines;
`endif

  // Increment as an enable chain rather than an adder: a digit at 9 or an
  // illegal code above 9 rolls to 0 and lets the next digit step.
  always_comb begin
    q_inc = q;
    run   = 1'b1;
`ifdef BCD_COUNTER_SATURATE_EN
    next_all_nines = 1'b1;
`endif
    for (int k = 0; k < DIGITS; k++) begin
      if (run) begin
        if (q[4*k +: 4] >= 4'd9) q_inc[4*k +: 4] = 4'd0;
        else                     q_inc[4*k +: 4] = q[4*k +: 4] + 4'd1;
      end
      run = run && (q[4*k +: 4] >= 4'd9);
`ifdef BCD_COUNTER_SATURATE_EN
      next_all_nines = next_all_nines && (q_inc[4*k +: 4] == 4'd9);
`endif
    end
    wrap = run;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      q     <= '0;
      carry <= 1'b0;
    end else if (en) begin
`ifdef BCD_COUNTER_SATURATE_EN
      // Hold at all-9s; carry marks only the edge that arrives there.
      if (!wrap) begin
        q     <= q_inc;
        carry <= next_all_nines;
      end else begin
        carry <= 1'b0;
      end
`else
      q     <= q_inc;
      carry <= wrap;
`endif
    end else begin
      carry <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bcd_counter.sv
// tb/tb_bcd_counter.sv - directed self-checking bench for bcd_counter
module tb_bcd_counter;

  logic        clk = 1'b0;
  logic        clr;
  logic        en;
  logic [31:0] q;
  logic        carry;

  logic        clr2;
  logic        en2;
  logic [7:0]  q2;
  logic        carry2;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] up_exp [12] = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6,
                               32'h7, 32'h8, 32'h9, 32'h10, 32'h11, 32'h12};
  logic [31:0] tog_exp [20] = '{32'h1, 32'h1, 32'h2, 32'h2, 32'h3, 32'h3,
                                32'h4, 32'h4, 32'h5, 32'h5, 32'h6, 32'h6,
                                32'h7, 32'h7, 32'h8, 32'h8, 32'h9, 32'h9,
                                32'h10, 32'h10};

  bcd_counter #(.DIGITS(8)) dut (
    .clk   (clk),
    .clr   (clr),
    .en    (en),
    .q     (q),
    .carry (carry)
  );

  // Two-digit instance reaches its all-9s boundary in 99 edges.
  bcd_counter #(.DIGITS(2)) dut2 (
    .clk   (clk),
    .clr   (clr2),
    .en    (en2),
    .q     (q2),
    .carry (carry2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    clr  = 1'b1;
    en   = 1'b0;
    clr2 = 1'b1;
    en2  = 1'b0;

    // Clear held for two edges
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_q", q, 32'h0);
    chk("reset_carry", {31'b0, carry}, 32'h0);

    // Count up 12 edges: 1..9, 10, 11, 12 with no A-F digits
    clr = 1'b0;
    en  = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("up_%0d", i + 1), q, up_exp[i]);
    end
    chk("up_carry", {31'b0, carry}, 32'h0);

    // Asynchronous clear seen before any edge
    clr = 1'b1;
    #1;
    chk("clr_async_q", q, 32'h0);

    // 0 -> 99 -> 100 ripple across two digits
    @(negedge clk);
    clr = 1'b0;
    repeat (99) @(posedge clk);
    @(negedge clk);
    chk("ripple_99", q, 32'h99);
    @(posedge clk);
    @(negedge clk);
    chk("ripple_100", q, 32'h100);

    // Toggle en each cycle: only enabled edges advance
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    for (int i = 0; i < 20; i++) begin
      en = (i % 2 == 0);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("toggle_%0d", i), q, tog_exp[i]);
    end
    chk("toggle_carry", {31'b0, carry}, 32'h0);

    // Count to 1234, then clear mid-cycle with en held high
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    en  = 1'b1;
    repeat (1234) @(posedge clk);
    @(negedge clk);
    chk("pre_clr_1234", q, 32'h1234);
    #2;
    clr = 1'b1;
    #1;
    chk("midcycle_clr_q", q, 32'h0);
    chk("midcycle_clr_carry", {31'b0, carry}, 32'h0);

    // clr dominates en across several edges
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("clr_dominates_en", q, 32'h0);
    clr = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("resume_after_clr", q, 32'h1);

    // Boundary on the two-digit instance
    en = 1'b0;
    clr2 = 1'b0;
    en2  = 1'b1;
    repeat (99) @(posedge clk);
    @(negedge clk);
    chk("small_99", {24'b0, q2}, 32'h99);
`ifdef BCD_COUNTER_SATURATE_EN
    chk("small_arrive_carry", {31'b0, carry2}, 32'h1);
`else
    chk("small_99_carry", {31'b0, carry2}, 32'h0);
`endif
    @(posedge clk);
    @(negedge clk);
`ifdef BCD_COUNTER_SATURATE_EN
    chk("small_sat_q", {24'b0, q2}, 32'h99);
    chk("small_sat_carry", {31'b0, carry2}, 32'h0);
`else
    chk("small_wrap_q", {24'b0, q2}, 32'h0);
    chk("small_wrap_carry", {31'b0, carry2}, 32'h1);
`endif
    @(posedge clk);
    @(negedge clk);
`ifdef BCD_COUNTER_SATURATE_EN
    chk("small_hold_q", {24'b0, q2}, 32'h99);
`else
    chk("small_after_wrap_q", {24'b0, q2}, 32'h1);
`endif
    chk("small_carry_one_cycle", {31'b0, carry2}, 32'h0);
    chk("main_idle_hold", q, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
